uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Controller that sequences the UART receiver output into the 4-bit CPU program memory.
- Consumes received bytes and their valid strobe, detects a sync byte, then a length byte, then N data bytes.
- Each data byte is split into two nibble writes, low nibble first, at consecutive memory addresses.
- Holds the CPU halted while loading; reports completion with a done strobe and failure with a sticky error flag.

Parameters:
- ADDR_WIDTH, 5, program memory nibble address width (depth 2^ADDR_WIDTH).
- SYNC_BYTE, 8'hA5, byte value that opens a programming session.
- TIMEOUT_CYCLES, 52100, idle clock cycles allowed between bytes inside a session (about 10 byte times at 19200 baud, 10 MHz).
- TIMEOUT_COUNTER_BITWIDTH, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  input  1  system clock, single clock domain.
- reset_ni  input  1  asynchronous, active-low reset.
- rx_data_i  input  8  received byte from the UART receiver; valid only while rx_valid_strb_i is high.
- rx_valid_strb_i  input  1  one-cycle strobe, byte available.
- mem_we_o  output  1  program memory write enable, one cycle per nibble.
- mem_addr_o  output  ADDR_WIDTH  program memory write address.
- mem_data_o  output  4  program memory write nibble.
- cpu_halt_o  output  1  high while a session is active; the CPU must not fetch.
- prog_done_strb_o  output  1  one-cycle pulse on successful session end.
- error_o  output  1  sticky; set on timeout or overrun, cleared when the next sync byte is accepted.

Behaviour:
- Reset (reset_ni low, asynchronous): state stIDLE; address, byte counter, data latch and timeout counter are 0; all outputs are 0.
- stIDLE:
  - On strobe with rx_data_i == SYNC_BYTE: go to stLENGTH, clear the address to 0, clear error_o, clear the timeout counter.
  - Any other byte is ignored.
- stLENGTH: on strobe, latch the length into an 8-bit remaining-byte counter.
  - Length 0: go to stDONE (empty session, no writes).
  - Otherwise: go to stDATA.
- stDATA: on strobe, latch the byte and go to stWR_LO. A SYNC_BYTE value here is plain data; there is no resync.
- stWR_LO (exactly 1 cycle):
  - mem_we_o=1, mem_addr_o=addr, mem_data_o=byte[3:0].
  - addr increments; go to stWR_HI.
- stWR_HI (exactly 1 cycle):
  - mem_we_o=1, mem_addr_o=addr, mem_data_o=byte[7:4].
  - addr increments; remaining counter decrements.
  - If the decremented count is 0, go to stDONE; else go to stDATA.
- stDONE (1 cycle): prog_done_strb_o=1 with cpu_halt_o still 1; next state stIDLE.
- Latency: strobe at cycle t -> low-nibble write at t+1, high-nibble write at t+2. For the last byte, the done pulse is at t+3 and cpu_halt_o is low from t+4.
- mem_we_o/mem_addr_o/mem_data_o are decoded from registered state only (Moore). mem_addr_o holds its value and mem_data_o is 0 when mem_we_o is low.
- cpu_halt_o=1 in stLENGTH, stDATA, stWR_LO, stWR_HI and stDONE; 0 in stIDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: writes past the top wrap to 0, with no error.
- Timeout:
  - The counter runs in stLENGTH and stDATA and clears on every accepted strobe.
  - When it reaches TIMEOUT_CYCLES-1 without a strobe: go to stIDLE, set error_o, release halt, no done pulse.
  - A strobe in the same cycle as terminal count wins: the byte is accepted and there is no timeout.
- Overrun: a strobe during stWR_LO/stWR_HI drops that byte and sets error_o. The session continues and the remaining count is unchanged.
- Reset mid-session: all state returns to reset values immediately, halt drops, and no done pulse is produced.

Test Plan:
- Reset, then send A5, 02, 3C, 7E -> writes (0,C),(1,3),(2,E),(3,7); done pulse 3 cycles after the 7E strobe; halt high from the A5+1 cycle to done; error_o=0.
- In idle send 11, FF, then A5, 00 -> no writes for 11/FF; halt rises after A5; done pulse 1 cycle after the 00 strobe; no mem_we_o ever.
- TIMEOUT_CYCLES=100: send A5, 03, 55, then nothing -> 2 writes, then 100 cycles later state idle, error_o=1, halt=0, no done; a later A5 clears error_o.
- Send A5, 11 (17 bytes) with ADDR_WIDTH=5 -> 34 nibble writes; the last two land at addresses 0 and 1 (wrap); done pulse; error_o=0.
- Force a strobe 1 cycle after a data strobe (during stWR_LO) -> that byte is not written, error_o=1, the session completes after the remaining bytes.
- Pull reset_ni low during stWR_HI -> mem_we_o, cpu_halt_o and prog_done_strb_o are 0 asynchronously; after release, idle waits for A5.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: sequences bytes from a UART receiver into a 4-bit wide program memory.
// A session is SYNC_BYTE, a length byte N, then N data bytes. Each data byte is written as
// two nibbles, low nibble first, at consecutive addresses starting from 0. The CPU is held
// halted for the whole session.
//
// Ports:
//   clk_i             system clock
//   reset_ni          asynchronous active-low reset
//   rx_data_i         received byte, valid while rx_valid_strb_i is high
//   rx_valid_strb_i   one-cycle byte-available strobe
//   mem_we_o          program memory write enable, one cycle per nibble
//   mem_addr_o        program memory nibble address
//   mem_data_o        program memory write nibble (0 when mem_we_o is low)
//   cpu_halt_o        high while a session is active
//   prog_done_strb_o  one-cycle pulse on successful session end
//   error_o           sticky timeout/overrun flag, cleared by the next accepted sync byte
module uart_prog_loader #(
    parameter int unsigned ADDR_WIDTH               = 5,
    parameter logic [7:0]  SYNC_BYTE                = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES           = 52100,
    parameter int unsigned TIMEOUT_COUNTER_BITWIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_strb_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_data_o,
    output logic                  cpu_halt_o,
    output logic                  prog_done_strb_o,
    output logic                  error_o
);

    localparam int unsigned TW = TIMEOUT_COUNTER_BITWIDTH;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLength,
        StData,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]            cnt_q,   cnt_d;
    logic [7:0]            byte_q,  byte_d;
    logic [TW-1:0]         tmo_q,   tmo_d;
    logic                  err_q,   err_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (rx_valid_strb_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d = StLength;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            StLength, StData: begin
                // An incoming byte beats a timeout that expires in the same cycle.
                if (rx_valid_strb_i) begin
                    tmo_d = '0;
                    if (state_q == StLength) begin
                        cnt_d   = rx_data_i;
                        state_d = (rx_data_i == 8'd0) ? StDone : StData;
                    end else begin
                        byte_d  = rx_data_i;
                        state_d = StWrLo;
                    end
                end else if (tmo_q == TmoLast) begin
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StWrLo: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = StWrHi;
                // A byte arriving mid-write is dropped and flagged.
                if (rx_valid_strb_i) begin
                    err_d = 1'b1;
                end
            end
            StWrHi: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? StDone : StData;
                if (rx_valid_strb_i) begin
                    err_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_we_o         = 1'b0;
        mem_data_o       = 4'h0;
        mem_addr_o       = addr_q;
        cpu_halt_o       = (state_q != StIdle);
        prog_done_strb_o = (state_q == StDone);
        error_o          = err_q;
        if (state_q == StWrLo) begin
            mem_we_o   = 1'b1;
            mem_data_o = byte_q[3:0];
        end else if (state_q == StWrHi) begin
            mem_we_o   = 1'b1;
            mem_data_o = byte_q[7:4];
        end
    end

endmodule
